// File: rtl/mgmt_data_channel_req_tracker.sv
// Host-side request tracker for the management data channel: tags one host
// register access, issues it to the channel controller and returns one completion.
package mgmt_data_channel_pkg;

    typedef enum logic [2:0] {
        READ_REQ  = 3'd0,
        WRITE_REQ = 3'd1,
        READ_RSP  = 3'd2,
        WRITE_RSP = 3'd3,
        CRC_ERROR = 3'd4
    } Data_channel_cmd_t;

    typedef struct packed {
        logic [7:0]        tag;
        Data_channel_cmd_t command;
        logic [31:0]       address;
        logic [3:0]        byte_en;
        logic [31:0]       data;
        logic [1:0]        operation_status;
    } Data_channel_payload_t;

endpackage

module mgmt_data_channel_req_tracker
    import mgmt_data_channel_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_RETRY      = 2,
    parameter logic [7:0]  TAG_INIT       = 8'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic                  host_req_write,
    input  logic [31:0]           host_req_addr,
    input  logic [31:0]           host_req_wdata,
    input  logic [3:0]            host_req_byte_en,
    output logic                  host_cpl_valid,
    output logic [31:0]           host_cpl_rdata,
    output logic [1:0]            host_cpl_status,
    input  logic                  link_operational,
    output logic                  req_valid,
    input  logic                  req_ack,
    output Data_channel_payload_t req_data_channel,
    input  logic                  res_valid,
    input  Data_channel_payload_t res_data_channel,
    output logic [15:0]           retry_cnt,
    output logic [15:0]           timeout_cnt,
    output logic [15:0]           stale_rsp_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_REMOTE  = 2'b01;
    localparam logic [1:0] ST_CRC     = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    state_t                r_state;
    state_t                w_next_state;
    logic [7:0]            r_tag;
    Data_channel_payload_t r_payload;
    logic                  r_is_write;
    logic [31:0]           r_retry;
    logic [31:0]           r_timer;
    logic [31:0]           r_cpl_rdata;
    logic [1:0]            r_cpl_status;
    logic [15:0]           r_retry_cnt;
    logic [15:0]           r_timeout_cnt;
    logic [15:0]           r_stale_cnt;

    logic                  w_match;
    logic                  w_accept;
    logic                  w_enter_wait;
    logic                  w_retry;
    logic                  w_finish;
    logic                  w_timeout_evt;
    logic                  w_stale;
    logic [1:0]            w_cpl_status;
    logic [31:0]           w_cpl_rdata;
    logic                  w_unused_rsp;

    // Ready is gated by reset so every output reads zero while reset is held.
    assign host_req_ready   = (r_state == IDLE) && link_operational && !reset;
    assign req_valid        = (r_state == ISSUE);
    assign host_cpl_valid   = (r_state == COMPLETE);
    assign host_cpl_rdata   = r_cpl_rdata;
    assign host_cpl_status  = r_cpl_status;
    assign req_data_channel = r_payload;
    assign retry_cnt        = r_retry_cnt;
    assign timeout_cnt      = r_timeout_cnt;
    assign stale_rsp_cnt    = r_stale_cnt;

    assign w_match      = res_valid && (res_data_channel.tag == r_tag);
    assign w_unused_rsp = ^{res_data_channel.address, res_data_channel.byte_en};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priorities: a matching response beats link drop and timer expiry;
    // a link drop in ISSUE beats a same-cycle ack.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_enter_wait  = 1'b0;
        w_retry       = 1'b0;
        w_finish      = 1'b0;
        w_timeout_evt = 1'b0;
        w_stale       = res_valid;
        w_cpl_status  = ST_OK;
        w_cpl_rdata   = 32'd0;
        case (r_state)
            IDLE: begin
                if (host_req_valid && host_req_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (!link_operational) begin
                    w_finish      = 1'b1;
                    w_timeout_evt = 1'b1;
                    w_cpl_status  = ST_TIMEOUT;
                end else if (req_ack) begin
                    w_enter_wait = 1'b1;
                    w_next_state = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                w_stale = res_valid && !w_match;
                if (w_match) begin
                    if (res_data_channel.command == CRC_ERROR) begin
                        if (r_retry < MAX_RETRY) begin
                            w_retry      = 1'b1;
                            w_next_state = ISSUE;
                        end else begin
                            w_finish     = 1'b1;
                            w_cpl_status = ST_CRC;
                        end
                    end else if (res_data_channel.operation_status != 2'd0) begin
                        w_finish     = 1'b1;
                        w_cpl_status = ST_REMOTE;
                        w_cpl_rdata  = res_data_channel.data;
                    end else begin
                        w_finish     = 1'b1;
                        w_cpl_status = ST_OK;
                        w_cpl_rdata  = r_is_write ? 32'd0 : res_data_channel.data;
                    end
                end else if (!link_operational || (r_timer == TIMEOUT_CYCLES - 1)) begin
                    w_finish      = 1'b1;
                    w_timeout_evt = 1'b1;
                    w_cpl_status  = ST_TIMEOUT;
                end
            end
            COMPLETE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (w_finish) begin
            w_next_state = COMPLETE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag         <= TAG_INIT;
            r_payload     <= '0;
            r_is_write    <= 1'b0;
            r_retry       <= 32'd0;
            r_timer       <= 32'd0;
            r_cpl_rdata   <= 32'd0;
            r_cpl_status  <= 2'd0;
            r_retry_cnt   <= 16'd0;
            r_timeout_cnt <= 16'd0;
            r_stale_cnt   <= 16'd0;
        end else begin
            if (w_accept) begin
                r_payload.tag              <= r_tag;
                r_payload.command          <= host_req_write ? WRITE_REQ : READ_REQ;
                r_payload.address          <= host_req_addr;
                r_payload.byte_en          <= host_req_byte_en;
                r_payload.data             <= host_req_write ? host_req_wdata : 32'd0;
                r_payload.operation_status <= 2'd0;
                r_is_write                 <= host_req_write;
                r_retry                    <= 32'd0;
            end
            if (w_enter_wait) begin
                r_timer <= 32'd0;
            end else if (r_state == WAIT_RSP) begin
                r_timer <= r_timer + 32'd1;
            end
            if (w_retry) begin
                r_retry <= r_retry + 32'd1;
                if (r_retry_cnt != 16'hFFFF) begin
                    r_retry_cnt <= r_retry_cnt + 16'd1;
                end
            end
            if (w_finish) begin
                r_cpl_status <= w_cpl_status;
                r_cpl_rdata  <= w_cpl_rdata;
            end
            // The tag advances on every completion, error or not, wrapping at 256.
            if (r_state == COMPLETE) begin
                r_tag <= r_tag + 8'd1;
            end
            if (w_timeout_evt && (r_timeout_cnt != 16'hFFFF)) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
            if (w_stale && (r_stale_cnt != 16'hFFFF)) begin
                r_stale_cnt <= r_stale_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mgmt_data_channel_req_tracker.sv
// Self-checking bench for mgmt_data_channel_req_tracker: scenario tasks push
// expected completions to a scoreboard that a negedge monitor pops and compares.
module tb_mgmt_data_channel_req_tracker;
    import mgmt_data_channel_pkg::*;

    localparam int unsigned TO = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  host_req_valid;
    logic                  host_req_ready;
    logic                  host_req_write;
    logic [31:0]           host_req_addr;
    logic [31:0]           host_req_wdata;
    logic [3:0]            host_req_byte_en;
    logic                  host_cpl_valid;
    logic [31:0]           host_cpl_rdata;
    logic [1:0]            host_cpl_status;
    logic                  link_operational;
    logic                  req_valid;
    logic                  req_ack;
    Data_channel_payload_t req_data_channel;
    logic                  res_valid;
    Data_channel_payload_t res_data_channel;
    logic [15:0]           retry_cnt;
    logic [15:0]           timeout_cnt;
    logic [15:0]           stale_rsp_cnt;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] rdata;
    } cpl_t;

    cpl_t        expQ[$];
    int          errors   = 0;
    int          checks   = 0;
    int          cplCount = 0;
    logic [7:0]  tbTag;
    logic [15:0] tbRetry;
    logic [15:0] tbTimeout;
    logic [15:0] tbStale;

    mgmt_data_channel_req_tracker #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(2),
        .TAG_INIT(8'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .host_req_valid(host_req_valid),
        .host_req_ready(host_req_ready),
        .host_req_write(host_req_write),
        .host_req_addr(host_req_addr),
        .host_req_wdata(host_req_wdata),
        .host_req_byte_en(host_req_byte_en),
        .host_cpl_valid(host_cpl_valid),
        .host_cpl_rdata(host_cpl_rdata),
        .host_cpl_status(host_cpl_status),
        .link_operational(link_operational),
        .req_valid(req_valid),
        .req_ack(req_ack),
        .req_data_channel(req_data_channel),
        .res_valid(res_valid),
        .res_data_channel(res_data_channel),
        .retry_cnt(retry_cnt),
        .timeout_cnt(timeout_cnt),
        .stale_rsp_cnt(stale_rsp_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        cpl_t e;
        if (host_cpl_valid === 1'b1) begin
            cplCount++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL cpl_unexpected: got status=%b rdata=%h, required no completion",
                         host_cpl_status, host_cpl_rdata);
            end else begin
                e = expQ.pop_front();
                if (host_cpl_status !== e.status || host_cpl_rdata !== e.rdata) begin
                    errors++;
                    $display("[TB] FAIL cpl_data: got status=%b rdata=%h, required status=%b rdata=%h",
                             host_cpl_status, host_cpl_rdata, e.status, e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic Data_channel_payload_t mkReq(input logic wr, input logic [31:0] addr,
                                                    input logic [31:0] wdata, input logic [3:0] be,
                                                    input logic [7:0] tag);
        Data_channel_payload_t p;
        p = '0;
        p.tag     = tag;
        p.command = wr ? WRITE_REQ : READ_REQ;
        p.address = addr;
        p.byte_en = be;
        p.data    = wr ? wdata : 32'd0;
        return p;
    endfunction

    task automatic pushExp(input logic [1:0] st, input logic [31:0] rd);
        cpl_t e;
        e.status = st;
        e.rdata  = rd;
        expQ.push_back(e);
        tbTag = tbTag + 8'd1;
    endtask

    task automatic sendReq(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
        int n;
        n = 0;
        while (host_req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_wait: got host_req_ready=%b, required 1 within 20 cycles", host_req_ready);
        end
        host_req_valid   = 1'b1;
        host_req_write   = wr;
        host_req_addr    = addr;
        host_req_wdata   = wdata;
        host_req_byte_en = be;
        tick();
        host_req_valid   = 1'b0;
    endtask

    task automatic doAck();
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
    endtask

    task automatic sendRsp(input logic [7:0] tag, input Data_channel_cmd_t cmd,
                           input logic [31:0] data, input logic [1:0] opst);
        Data_channel_payload_t p;
        p = '0;
        p.tag              = tag;
        p.command          = cmd;
        p.data             = data;
        p.operation_status = opst;
        res_data_channel   = p;
        res_valid          = 1'b1;
        tick();
        res_valid          = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({req_valid, host_cpl_valid, host_req_ready, host_cpl_status, host_cpl_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got rv=%b cv=%b rdy=%b st=%b rd=%h, required all 0",
                     req_valid, host_cpl_valid, host_req_ready, host_cpl_status, host_cpl_rdata);
        end
        checks++;
        if ({retry_cnt, timeout_cnt, stale_rsp_cnt, req_data_channel} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got retry=%0d to=%0d stale=%0d payload=%h, required 0",
                     retry_cnt, timeout_cnt, stale_rsp_cnt, req_data_channel);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        tbTag = 8'd0; tbRetry = '0; tbTimeout = '0; tbStale = '0;
        checks++;
        if (host_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got %b, required 1", host_req_ready);
        end
    endtask

    task automatic test_read_normal();
        Data_channel_payload_t p;
        p = mkReq(1'b0, 32'h0000_0010, 32'h1111_2222, 4'hF, tbTag);
        sendReq(1'b0, 32'h0000_0010, 32'h1111_2222, 4'hF);
        checks++;
        if (req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_req_valid: got %b, required 1", req_valid);
        end
        checks++;
        if (req_data_channel !== p) begin
            errors++;
            $display("[TB] FAIL read_payload: got %h, required %h", req_data_channel, p);
        end
        doAck();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_req_drop: got %b, required 0", req_valid);
        end
        pushExp(2'b00, 32'hCAFE_F00D);
        sendRsp(p.tag, READ_RSP, 32'hCAFE_F00D, 2'd0);
        checks++;
        if (host_cpl_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_cpl_latency: got %b, required 1", host_cpl_valid);
        end
        tick();
        checks++;
        if (host_cpl_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_cpl_single: got %b, required 0", host_cpl_valid);
        end
    endtask

    task automatic test_write_delayed_ack();
        Data_channel_payload_t p;
        p = mkReq(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, tbTag);
        sendReq(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (req_valid !== 1'b1 || req_data_channel !== p) begin
                errors++;
                $display("[TB] FAIL write_hold[%0d]: got rv=%b payload=%h, required rv=1 payload=%h",
                         i, req_valid, req_data_channel, p);
            end
            tick();
        end
        doAck();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_req_drop: got %b, required 0", req_valid);
        end
        pushExp(2'b00, 32'd0);
        sendRsp(p.tag, WRITE_RSP, 32'hDEAD_BEEF, 2'd0);
        tick();
    endtask

    task automatic test_crc_retry();
        Data_channel_payload_t p;
        p = mkReq(1'b0, 32'h0000_0040, 32'd0, 4'hF, tbTag);
        sendReq(1'b0, 32'h0000_0040, 32'd0, 4'hF);
        for (int r = 0; r < 2; r++) begin
            doAck();
            sendRsp(p.tag, CRC_ERROR, 32'h0BAD_0BAD, 2'd0);
            tbRetry = tbRetry + 16'd1;
            checks++;
            if (req_valid !== 1'b1 || req_data_channel !== p) begin
                errors++;
                $display("[TB] FAIL crc_reissue[%0d]: got rv=%b payload=%h, required rv=1 payload=%h",
                         r, req_valid, req_data_channel, p);
            end
        end
        doAck();
        pushExp(2'b00, 32'h0000_55AA);
        sendRsp(p.tag, READ_RSP, 32'h0000_55AA, 2'd0);
        checks++;
        if (retry_cnt !== tbRetry) begin
            errors++;
            $display("[TB] FAIL crc_retry_cnt: got %0d, required %0d", retry_cnt, tbRetry);
        end
        tick();

        p = mkReq(1'b0, 32'h0000_0044, 32'd0, 4'h1, tbTag);
        sendReq(1'b0, 32'h0000_0044, 32'd0, 4'h1);
        for (int r = 0; r < 2; r++) begin
            doAck();
            sendRsp(p.tag, CRC_ERROR, 32'h0BAD_0BAD, 2'd0);
            tbRetry = tbRetry + 16'd1;
        end
        doAck();
        pushExp(2'b10, 32'd0);
        sendRsp(p.tag, CRC_ERROR, 32'h0BAD_0BAD, 2'd0);
        checks++;
        if (host_cpl_valid !== 1'b1 || retry_cnt !== tbRetry) begin
            errors++;
            $display("[TB] FAIL crc_exhaust: got cv=%b retry=%0d, required cv=1 retry=%0d",
                     host_cpl_valid, retry_cnt, tbRetry);
        end
        tick();
    endtask

    task automatic test_remote_error();
        logic [7:0] t;
        t = tbTag;
        sendReq(1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 4'hF);
        doAck();
        pushExp(2'b01, 32'h0000_E001);
        sendRsp(t, WRITE_RSP, 32'h0000_E001, 2'd2);
        tick();
    endtask

    task automatic test_timeout();
        logic [7:0] t;
        int k;
        t = tbTag;
        sendReq(1'b0, 32'h0000_00C0, 32'd0, 4'hF);
        doAck();
        pushExp(2'b11, 32'd0);
        tbTimeout = tbTimeout + 16'd1;
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (host_cpl_valid === 1'b1) break;
        end
        checks++;
        if (k != TO) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d cycles, required %0d", k, TO);
        end
        checks++;
        if (timeout_cnt !== tbTimeout) begin
            errors++;
            $display("[TB] FAIL timeout_cnt: got %0d, required %0d", timeout_cnt, tbTimeout);
        end
        tick();
        k = cplCount;
        sendRsp(t, READ_RSP, 32'h7777_7777, 2'd0);
        tbStale = tbStale + 16'd1;
        repeat (3) tick();
        checks++;
        if (stale_rsp_cnt !== tbStale || cplCount != k) begin
            errors++;
            $display("[TB] FAIL late_rsp: got stale=%0d cpls=%0d, required stale=%0d cpls=%0d",
                     stale_rsp_cnt, cplCount, tbStale, k);
        end
    endtask

    task automatic test_tag_mismatch();
        logic [7:0] t;
        int c;
        t = tbTag;
        sendReq(1'b0, 32'h0000_0100, 32'd0, 4'hF);
        doAck();
        c = cplCount;
        sendRsp(t + 8'd1, READ_RSP, 32'h9999_9999, 2'd0);
        tbStale = tbStale + 16'd1;
        repeat (3) tick();
        checks++;
        if (stale_rsp_cnt !== tbStale || cplCount != c || req_valid !== 1'b0 || host_req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mismatch_ignored: got stale=%0d cpls=%0d rv=%b rdy=%b, required stale=%0d cpls=%0d rv=0 rdy=0",
                     stale_rsp_cnt, cplCount, req_valid, host_req_ready, tbStale, c);
        end
        pushExp(2'b00, 32'h0101_0101);
        sendRsp(t, READ_RSP, 32'h0101_0101, 2'd0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  start;
        logic        wr;
        logic [31:0] d;
        start = tbTag;
        for (int i = 0; i < 256; i++) begin
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            sendReq(wr, 32'h1000 + 32'(i), d, 4'hF);
            checks++;
            if (req_data_channel.tag !== tbTag) begin
                errors++;
                $display("[TB] FAIL b2b_tag[%0d]: got %h, required %h", i, req_data_channel.tag, tbTag);
            end
            doAck();
            if (wr) begin
                pushExp(2'b00, 32'd0);
                sendRsp(tbTag - 8'd1, WRITE_RSP, d, 2'd0);
            end else begin
                pushExp(2'b00, d);
                sendRsp(tbTag - 8'd1, READ_RSP, d, 2'd0);
            end
            tick();
        end
        checks++;
        if (tbTag !== start) begin
            errors++;
            $display("[TB] FAIL b2b_model_wrap: got %h, required %h", tbTag, start);
        end
    endtask

    task automatic test_reset_in_wait();
        int c;
        sendReq(1'b0, 32'h0000_0200, 32'd0, 4'hF);
        checks++;
        if (req_data_channel.tag !== tbTag) begin
            errors++;
            $display("[TB] FAIL wrap_tag: got %h, required %h", req_data_channel.tag, tbTag);
        end
        doAck();
        c = cplCount;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({req_valid, host_cpl_valid, host_req_ready, host_cpl_status, host_cpl_rdata,
             retry_cnt, timeout_cnt, stale_rsp_cnt, req_data_channel} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got rv=%b cv=%b rdy=%b retry=%0d to=%0d stale=%0d, required all 0",
                     req_valid, host_cpl_valid, host_req_ready, retry_cnt, timeout_cnt, stale_rsp_cnt);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        tbTag = 8'd0; tbRetry = '0; tbTimeout = '0; tbStale = '0;
        repeat (3) tick();
        checks++;
        if (cplCount != c) begin
            errors++;
            $display("[TB] FAIL reset_no_cpl: got %0d completions, required %0d", cplCount, c);
        end
    endtask

    task automatic test_link_drop();
        sendReq(1'b1, 32'h0000_0300, 32'h0F0F_0F0F, 4'hF);
        checks++;
        if (req_data_channel.tag !== tbTag) begin
            errors++;
            $display("[TB] FAIL tag_after_reset: got %h, required %h", req_data_channel.tag, tbTag);
        end
        pushExp(2'b11, 32'd0);
        tbTimeout = tbTimeout + 16'd1;
        link_operational = 1'b0;
        doAck();
        checks++;
        if (host_cpl_valid !== 1'b1 || req_valid !== 1'b0 || timeout_cnt !== tbTimeout) begin
            errors++;
            $display("[TB] FAIL link_drop: got cv=%b rv=%b to=%0d, required cv=1 rv=0 to=%0d",
                     host_cpl_valid, req_valid, timeout_cnt, tbTimeout);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (host_req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ready_link_down[%0d]: got %b, required 0", i, host_req_ready);
            end
        end
        link_operational = 1'b1;
        #1;
        checks++;
        if (host_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_link_up: got %b, required 1", host_req_ready);
        end
        tick();
    endtask

    initial begin
        reset            = 1'b1;
        host_req_valid   = 1'b0;
        host_req_write   = 1'b0;
        host_req_addr    = '0;
        host_req_wdata   = '0;
        host_req_byte_en = '0;
        link_operational = 1'b1;
        req_ack          = 1'b0;
        res_valid        = 1'b0;
        res_data_channel = '0;
        tbTag = 8'd0; tbRetry = '0; tbTimeout = '0; tbStale = '0;

        test_reset();
        test_read_normal();
        test_write_delayed_ack();
        test_crc_retry();
        test_remote_error();
        test_timeout();
        test_tag_mismatch();
        test_back_to_back();
        test_reset_in_wait();
        test_link_drop();

        repeat (2) tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mgmt_data_channel_req_tracker.md
Name: mgmt_data_channel_req_tracker

Overview:
- Host-facing front end for the management data channel.
- Accepts one register read/write from a local host (BMC/CSR bridge) and tags it.
- Presents the request to the data-channel controller with a valid/ack handshake, then waits for the tagged response.
- Retries on CRC error, times out on missing responses, and returns exactly one completion per accepted request.
- Single outstanding transaction.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles in WAIT_RSP before timeout completion (must be ≥2).
- MAX_RETRY, 2, reissues allowed after CRC_ERROR responses.
- TAG_INIT, 0, tag value after reset.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- host_req_valid  input  1  host request valid.
- host_req_ready  output  1  tracker can accept a request.
- host_req_write  input  1  1=write, 0=read.
- host_req_addr  input  32  register address.
- host_req_wdata  input  32  write data.
- host_req_byte_en  input  4  byte enables.
- host_cpl_valid  output  1  one-cycle completion pulse.
- host_cpl_rdata  output  32  read data; 0 for writes and for errors other than remote error.
- host_cpl_status  output  2  00 ok, 01 remote error, 10 CRC error after retries, 11 timeout/link abort.
- link_operational  input  1  local link state is operational.
- req_valid  output  1  request to data-channel controller.
- req_ack  input  1  controller accepted request.
- req_data_channel  output  Data_channel_payload_t  request payload.
- res_valid  input  1  response pulse from controller.
- res_data_channel  input  Data_channel_payload_t  response payload.
- retry_cnt  output  16  saturating count of CRC-triggered reissues.
- timeout_cnt  output  16  saturating count of status-11 completions.
- stale_rsp_cnt  output  16  saturating count of responses with a non-matching tag or received outside WAIT_RSP.

Behaviour:
- Reset (asynchronous, any state):
  - All outputs 0, FSM to IDLE, tag = TAG_INIT, retry counter and timer = 0.
  - An in-flight transaction is dropped with no completion.
- FSM states: IDLE, ISSUE, WAIT_RSP, COMPLETE.
- IDLE:
  - host_req_ready = link_operational (combinational from state and input); 0 in all other states.
  - On host_req_valid && host_req_ready at edge N, latch the request and build the payload:
    - tag = cur_tag;
    - command = WRITE_REQ or READ_REQ;
    - address, byte_en, data = wdata (0 for reads);
    - operation_status = 0.
  - Clear the retry counter and go to ISSUE. req_valid is high from N+1.
- ISSUE:
  - req_valid = 1; req_data_channel held stable.
  - On an edge sampling req_ack = 1: req_valid is 0 from the next cycle, clear the timer, go to WAIT_RSP.
  - No timeout in ISSUE.
- WAIT_RSP:
  - Timer increments by 1 per cycle.
  - A response matches when res_valid && res_data_channel.tag == cur_tag.
  - Matching response with command == CRC_ERROR:
    - if retry count < MAX_RETRY: increment retry count and retry_cnt, go to ISSUE with the identical payload (same tag);
    - otherwise: status 10, go to COMPLETE.
  - Matching response with operation_status != 0: status 01, rdata = response data, go to COMPLETE.
  - Other matching response: status 00, rdata = response data for reads and 0 for writes, go to COMPLETE.
  - Non-matching res_valid is ignored; increment stale_rsp_cnt.
  - When timer == TIMEOUT_CYCLES-1 with no matching response: status 11, increment timeout_cnt, go to COMPLETE.
- COMPLETE:
  - host_cpl_valid = 1 for exactly one cycle, with rdata/status stable during it.
  - cur_tag increments modulo 256 (255 wraps to 0) on every completion, including errors.
  - Return to IDLE.
  - Completion latency: matching response sampled at edge M gives host_cpl_valid high during cycle M+1.
- Link drop: link_operational = 0 sampled in ISSUE or WAIT_RSP gives status 11, go to COMPLETE (timeout_cnt increments). req_valid drops the next cycle.
- Simultaneous events:
  - A matching response and timer expiry in the same cycle: the response wins.
  - A matching response and link drop in the same cycle: the response wins.
  - req_ack and link drop in the same cycle: the link drop wins (abort).
- res_valid in IDLE, ISSUE or COMPLETE: ignored, stale_rsp_cnt increments.
- All counters saturate at 0xFFFF.

Test Plan:
- Read, normal path: tag 0, addr 0x0000_0010, response tag 0, data 0xCAFE_F00D, status 0 -> single host_cpl_valid, rdata 0xCAFE_F00D, status 00; next request carries tag 1.
- Write with req_ack delayed 5 cycles: req_valid held and payload stable for 5 cycles, then deasserts; response op status 0 -> status 00, rdata 0.
- CRC retry: first two responses CRC_ERROR with tag 0, third ok -> two reissues with tag 0, retry_cnt=2, status 00. With three CRC_ERRORs -> status 10, retry_cnt=2.
- Timeout with TIMEOUT_CYCLES=16, no response -> completion exactly 16 cycles after the ack edge, status 11, timeout_cnt=1. A response arriving later -> stale_rsp_cnt=1 and no second completion.
- Tag wrap and mismatch: 256 back-to-back transactions -> tag returns to 0. A response with tag cur_tag+1 during WAIT_RSP -> ignored, stale_rsp_cnt increments, FSM still waits.
- Async reset asserted in WAIT_RSP, and link drop in ISSUE:
  - reset -> all outputs 0 immediately, no completion, tag = TAG_INIT;
  - link drop -> status 11 completion, host_req_ready stays 0 until link_operational returns.
